fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Instruction-fetch sequencer that owns the program counter's control inputs (increment, bus load, MDR load) and the instruction-memory read handshake. It reads the word at the current PC, latches it into an instruction register, and advances the PC on the same edge. It presents the instruction to the decoder with a valid/ack handshake and applies jump loads only between fetches. It sits between the PC register, instruction memory and the decode/execute control unit.

Parameters:
WAIT_LIMIT, 16, max cycles in WAIT without mem_ready before fault; 0 disables the timeout
CNT_W, 16, width of fetch_count

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset
pc_val  in  16  current PC value from the PC register
mem_addr  out  16  instruction memory address
mem_rd  out  1  memory read request
mem_ready  in  1  memory data valid this cycle
mem_data  in  16  memory read data
ir  out  16  latched instruction
ir_valid  out  1  ir holds an unconsumed instruction
ir_ack  in  1  decoder consumed ir
jump_bus  in  1  request PC load from bus (decoder-driven, bus value handled externally)
jump_mdr  in  1  request PC load from MDR
halt  in  1  suppress new fetches
pc_inc  out  1  PC increment strobe
pc_bus_we  out  1  PC load-from-bus strobe
pc_mdr_we  out  1  PC load-from-MDR strobe
busy  out  1  fetch in progress (REQ or WAIT)
fault  out  1  sticky memory timeout flag
fetch_count  out  CNT_W  completed fetches, wraps

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, FAULT. Reset (rst=0, asynchronous) forces IDLE immediately; ir=0, fetch_count=0, timeout counter=0; every output 0, including during reset.
- IDLE: if halt=0, go to REQ next edge; else stay.
- REQ (1 cycle): mem_rd=1, mem_addr=pc_val, busy=1; go to WAIT.
- WAIT: mem_rd=1, mem_addr=pc_val, busy=1.
  - mem_ready=1: ir<=mem_data, pc_inc=1 combinationally that cycle (PC advances on the same edge), fetch_count+1, go to HOLD.
  - Timeout counter increments each WAIT cycle without mem_ready and clears on leaving WAIT.
  - WAIT_LIMIT>0 and counter reaches WAIT_LIMIT: go to FAULT; fault<=1.
- HOLD: ir_valid=1; mem_rd=0.
  - jump_bus=1: pc_bus_we=1 combinationally.
  - Else jump_mdr=1: pc_mdr_we=1.
  - Bus has priority; never both strobes asserted.
  - On any jump or ir_ack: leave HOLD, go to REQ if halt=0, else IDLE. ir_valid falls the next cycle.
  - Jump and ack in the same cycle: treated as one event, jump applied.
- Jump requests outside HOLD are ignored: strobes stay 0 and nothing is queued.
- pc_inc, pc_bus_we and pc_mdr_we are mutually exclusive in every cycle.
- halt is sampled only in IDLE and on HOLD exit. halt during REQ/WAIT does not abort the fetch in flight.
- FAULT: all strobes and mem_rd 0, fault=1, ir_valid=0. Exited only by reset.
- fetch_count wraps from all-ones to 0. ir is held unchanged outside a WAIT capture.
- mem_ready outside WAIT is ignored.

Test Plan:
- Reset, halt=0, pc_val=0x0010, mem_ready after 2 WAIT cycles with mem_data=0xA5A5 -> mem_rd high 3 cycles (REQ plus 2 WAIT), addr 0x0010; pc_inc exactly 1 cycle, coincident with mem_ready; ir=0xA5A5; ir_valid=1; fetch_count=1.
- HOLD with ir_ack=1, halt=0 -> ir_valid drops next cycle; REQ follows immediately; back-to-back fetches every 3 cycles with zero-wait memory.
- HOLD with jump_bus=1 and jump_mdr=1 together -> pc_bus_we=1 for 1 cycle, pc_mdr_we=0, pc_inc=0; next fetch uses the new pc_val.
- jump_mdr pulsed during WAIT -> pc_mdr_we stays 0, no state change. jump_mdr later in HOLD -> pc_mdr_we=1.
- WAIT_LIMIT=4, mem_ready held 0 -> FAULT after 4 WAIT cycles; fault=1, mem_rd=0; a later mem_ready has no effect; rst low clears fault.
- rst asserted mid-WAIT -> outputs 0 without a clock edge. After release with halt=1 -> stays IDLE, mem_rd=0. fetch_count forced to 0xFFFF via 65535 fetches (or reduced CNT_W=4, 15 fetches) -> next fetch wraps to 0.

Source files
------------

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - fetch sequencer bus bundle (PC controls, imem read, decoder handshake)
interface fetch_seq_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      pc_val;
  logic [15:0]      mem_addr;
  logic             mem_rd;
  logic             mem_ready;
  logic [15:0]      mem_data;
  logic [15:0]      ir;
  logic             ir_valid;
  logic             ir_ack;
  logic             jump_bus;
  logic             jump_mdr;
  logic             halt;
  logic             pc_inc;
  logic             pc_bus_we;
  logic             pc_mdr_we;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  pc_val, mem_ready, mem_data, ir_ack, jump_bus, jump_mdr, halt,
    output mem_addr, mem_rd, ir, ir_valid, pc_inc, pc_bus_we, pc_mdr_we,
           busy, fault, fetch_count
  );

  modport slave (
    output pc_val, mem_ready, mem_data, ir_ack, jump_bus, jump_mdr, halt,
    input  mem_addr, mem_rd, ir, ir_valid, pc_inc, pc_bus_we, pc_mdr_we,
           busy, fault, fetch_count
  );
endinterface

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer driving PC strobes and the imem read handshake
module fetch_seq #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  fetch_seq_if.master bus
);
  localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WC_W-1:0]  wait_cnt;
  logic             capture;
  logic             timeout;
  logic             leave_hold;

  // wait_cnt holds the number of earlier unanswered WAIT cycles, so this fires on the last allowed one
  assign timeout    = (WAIT_LIMIT > 0) && (int'(wait_cnt) >= WAIT_LIMIT - 1);
  assign leave_hold = bus.jump_bus | bus.jump_mdr | bus.ir_ack;

  assign bus.ir          = ir_q;
  assign bus.fetch_count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ir_q     <= '0;
      cnt_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        ir_q  <= bus.mem_data;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state == WAIT && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    capture       = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = '0;
    bus.busy      = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_bus_we = 1'b0;
    bus.pc_mdr_we = 1'b0;
    bus.ir_valid  = 1'b0;
    bus.fault     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.halt) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = bus.pc_val;
        bus.busy     = 1'b1;
        state_nx     = WAIT;
      end
      WAIT: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = bus.pc_val;
        bus.busy     = 1'b1;
        // PC increments on the same edge that captures the word it pointed at
        if (bus.mem_ready) begin
          bus.pc_inc = 1'b1;
          capture    = 1'b1;
          state_nx   = HOLD;
        end else if (timeout) begin
          state_nx = FAULT;
        end
      end
      HOLD: begin
        bus.ir_valid = 1'b1;
        if (bus.jump_bus) begin
          bus.pc_bus_we = 1'b1;
        end else if (bus.jump_mdr) begin
          bus.pc_mdr_we = 1'b1;
        end
        if (leave_hold) begin
          state_nx = bus.halt ? IDLE : REQ;
        end
      end
      FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - fetch_seq bench: transaction-level model, directed scenarios and random traffic
module tb_fetch_seq;
  localparam int WL = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_seq_if #(.CNT_W(CW)) bus ();

  fetch_seq #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  assign bus.mem_data = mem_word(bus.mem_addr);

  int total = 0;
  int bad   = 0;

  // model: a fetch is either being requested (first cycle) or awaiting data, an instruction is held, or the unit is dead
  bit          m_fetch, m_first, m_hold, m_dead;
  int          m_waited;
  logic [15:0] m_ir;
  int          m_fc;

  logic [15:0] pc, bus_val, mdr_val;
  int rd_cnt, inc_cnt, inc_rdy_cnt, bwe_cnt, mwe_cnt, streak;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fetch = 0; m_first = 0; m_hold = 0; m_dead = 0;
    m_waited = 0; m_ir = 16'h0; m_fc = 0;
  endtask

  task automatic clr_obs();
    rd_cnt = 0; inc_cnt = 0; inc_rdy_cnt = 0; bwe_cnt = 0; mwe_cnt = 0;
  endtask

  task automatic step();
    logic s_inc, s_bwe, s_mwe;
    @(negedge clk);
    if (!rst) model_clear();
    chk("mem_rd", bus.mem_rd, m_fetch);
    chk("mem_addr", bus.mem_addr, m_fetch ? bus.pc_val : 16'h0);
    chk("busy", bus.busy, m_fetch);
    chk("pc_inc", bus.pc_inc, m_fetch && !m_first && bus.mem_ready);
    chk("ir_valid", bus.ir_valid, m_hold);
    chk("pc_bus_we", bus.pc_bus_we, m_hold && bus.jump_bus);
    chk("pc_mdr_we", bus.pc_mdr_we, m_hold && !bus.jump_bus && bus.jump_mdr);
    chk("fault", bus.fault, m_dead);
    chk("ir", bus.ir, m_ir);
    chk("fetch_count", 32'(bus.fetch_count), 32'(m_fc % (1 << CW)));
    chk("strobe_excl", (int'(bus.pc_inc) + int'(bus.pc_bus_we) + int'(bus.pc_mdr_we)) <= 1, 1);
    s_inc = bus.pc_inc; s_bwe = bus.pc_bus_we; s_mwe = bus.pc_mdr_we;
    rd_cnt      += int'(bus.mem_rd);
    inc_cnt     += int'(s_inc);
    inc_rdy_cnt += int'(s_inc && bus.mem_ready);
    bwe_cnt     += int'(s_bwe);
    mwe_cnt     += int'(s_mwe);
    streak = (bus.mem_rd && !bus.mem_ready) ? streak + 1 : 0;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (m_dead) begin
      m_dead = 1;
    end else if (m_hold) begin
      if (bus.jump_bus || bus.jump_mdr || bus.ir_ack) begin
        m_hold  = 0;
        m_fetch = !bus.halt;
        m_first = !bus.halt;
      end
    end else if (m_fetch && m_first) begin
      m_first  = 0;
      m_waited = 0;
    end else if (m_fetch) begin
      if (bus.mem_ready) begin
        m_ir = mem_word(bus.pc_val);
        m_fc++;
        m_fetch = 0;
        m_hold  = 1;
      end else begin
        m_waited++;
        if (m_waited == WL) begin
          m_dead  = 1;
          m_fetch = 0;
        end
      end
    end else if (!bus.halt) begin
      m_fetch = 1;
      m_first = 1;
    end
    #1;
    if (s_inc) pc = pc + 16'h1;
    else if (s_bwe) pc = bus_val;
    else if (s_mwe) pc = mdr_val;
    bus.pc_val = pc;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    pc = 16'h0010; bus.pc_val = pc; bus_val = 16'h0; mdr_val = 16'h0;
    bus.mem_ready = 0; bus.ir_ack = 0; bus.jump_bus = 0; bus.jump_mdr = 0; bus.halt = 0;
    streak = 0;
    clr_obs();
    model_clear();
    #12;
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_fetch_count", 32'(bus.fetch_count), 0);
    chk("rst_fault", bus.fault, 0);
    step();
    rst = 1'b1;

    // first fetch: two WAIT cycles, data on the second
    step();
    clr_obs();
    step();
    step();
    bus.mem_ready = 1; step();
    bus.mem_ready = 0;
    chk("t1_rd_cycles", rd_cnt, 3);
    chk("t1_inc_cycles", inc_cnt, 1);
    chk("t1_inc_with_ready", inc_rdy_cnt, 1);
    chk("t1_ir", bus.ir, 16'hA5A5);
    chk("t1_ir_valid", bus.ir_valid, 1);
    chk("t1_fetch_count", 32'(bus.fetch_count), 1);
    chk("t1_pc", pc, 16'h0011);

    // back-to-back zero-wait fetches with immediate ack
    bus.ir_ack = 1; bus.mem_ready = 1;
    clr_obs();
    repeat (9) step();
    chk("t2_inc_cycles", inc_cnt, 3);
    chk("t2_fetch_count", 32'(bus.fetch_count), 4);
    chk("t2_ir", bus.ir, 16'h0134);
    chk("t2_ir_valid", bus.ir_valid, 1);

    // simultaneous jump requests: bus wins
    bus.ir_ack = 0; bus.mem_ready = 0;
    bus.jump_bus = 1; bus.jump_mdr = 1; bus_val = 16'h0200; mdr_val = 16'h0300;
    clr_obs();
    step();
    bus.jump_bus = 0; bus.jump_mdr = 0;
    chk("t3_bus_we", bwe_cnt, 1);
    chk("t3_mdr_we", mwe_cnt, 0);
    chk("t3_inc", inc_cnt, 0);
    chk("t3_pc", pc, 16'h0200);
    bus.mem_ready = 1; step(); step();
    bus.mem_ready = 0;
    chk("t3_ir", bus.ir, 16'h1236);
    chk("t3_pc_after", pc, 16'h0201);
    chk("t3_fetch_count", 32'(bus.fetch_count), 5);

    // jump_mdr in WAIT ignored, honoured later in HOLD
    bus.ir_ack = 1; step();
    bus.ir_ack = 0; step();
    clr_obs();
    bus.jump_mdr = 1; step();
    bus.jump_mdr = 0;
    chk("t4_wait_mdr_we", mwe_cnt, 0);
    chk("t4_still_busy", bus.busy, 1);
    bus.mem_ready = 1; step();
    bus.mem_ready = 0;
    bus.jump_mdr = 1; step();
    bus.jump_mdr = 0;
    chk("t4_hold_mdr_we", mwe_cnt, 1);
    chk("t4_pc", pc, 16'h0300);
    bus.mem_ready = 1; step(); step();
    bus.mem_ready = 0;
    chk("t4_ir", bus.ir, 16'h1237);
    chk("t4_fetch_count", 32'(bus.fetch_count), 7);

    // random traffic; memory never leaves a request unanswered long enough to time out
    for (int i = 0; i < 500; i++) begin
      bus.halt      = ($urandom_range(0, 9) == 0);
      bus.ir_ack    = ($urandom_range(0, 2) == 0);
      bus.jump_bus  = ($urandom_range(0, 15) == 0);
      bus.jump_mdr  = ($urandom_range(0, 11) == 0);
      bus.mem_ready = (streak >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus_val = 16'($urandom);
      mdr_val = 16'($urandom);
      step();
    end

    // fetch_count wrap
    bus.halt = 0; bus.jump_bus = 0; bus.jump_mdr = 0; bus.ir_ack = 1; bus.mem_ready = 1;
    n = 0;
    while (bus.fetch_count != 4'hF && n < 80) begin step(); n++; end
    chk("wrap_reach_max", 32'(bus.fetch_count), 15);
    n = 0;
    while (bus.fetch_count == 4'hF && n < 10) begin step(); n++; end
    chk("wrap_to_zero", 32'(bus.fetch_count), 0);

    // memory timeout
    bus.mem_ready = 0;
    step();
    bus.ir_ack = 0;
    clr_obs();
    n = 0;
    while (!bus.fault && n < 20) begin step(); n++; end
    chk("t6_fault", bus.fault, 1);
    chk("t6_rd_cycles", rd_cnt, 5);
    chk("t6_mem_rd", bus.mem_rd, 0);
    chk("t6_ir_valid", bus.ir_valid, 0);
    bus.mem_ready = 1;
    repeat (3) step();
    bus.mem_ready = 0;
    chk("t6_fault_sticky", bus.fault, 1);
    chk("t6_fetch_count", 32'(bus.fetch_count), 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_clears_fault", bus.fault, 0);
    step();
    rst = 1'b1;

    // reset mid-WAIT, then halted restart
    bus.halt = 0;
    step(); step();
    chk("t7_in_wait", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t7_async_mem_rd", bus.mem_rd, 0);
    chk("t7_async_busy", bus.busy, 0);
    chk("t7_async_ir", bus.ir, 0);
    chk("t7_async_fetch_count", 32'(bus.fetch_count), 0);
    bus.halt = 1;
    step();
    rst = 1'b1;
    clr_obs();
    repeat (5) step();
    chk("t7_halt_rd_cycles", rd_cnt, 0);
    chk("t7_halt_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
